uart_crc_frame_rx: RTL and testbench

//  Frame deframer/checker sitting directly downstream of the UART receiver.
//  - Consumes the received byte stream (rx_data_valid_o/rx_data_o of the UART).
//  - Frame format: LEN byte, then LEN payload bytes, then one CRC-8 byte.
//  - Buffers the payload and releases it on a valid/ready stream only if the CRC matches.
//  - Reports per-frame status and keeps a saturating error count.

---
 rtl/uart_crc_pkg.sv | 29 ++
 rtl/uart_crc_frame_rx_if.sv | 24 ++
 rtl/uart_frame_buf.sv | 32 +++
 rtl/uart_crc_frame_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_crc_frame_rx.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_crc_pkg.sv
// Shared types and the CRC-8 (poly 0x07, MSB-first) byte update for the frame receiver.
package uart_crc_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CRC     = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_crc_frame_rx_if.sv
// Byte-stream input, payload output stream and status bundle of the CRC frame receiver.
interface uart_crc_frame_rx_if;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic        out_last_o;
  logic        out_ready_i;
  logic        frame_ok_o;
  logic        frame_err_o;
  logic [1:0]  err_code_o;
  logic [15:0] err_cnt_o;
  logic        err_clr_i;

  modport master (
    output rx_valid_i, rx_data_i, out_ready_i, err_clr_i,
    input  out_valid_o, out_data_o, out_last_o, frame_ok_o, frame_err_o, err_code_o, err_cnt_o
  );

  modport slave (
    input  rx_valid_i, rx_data_i, out_ready_i, err_clr_i,
    output out_valid_o, out_data_o, out_last_o, frame_ok_o, frame_err_o, err_code_o, err_cnt_o
  );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM, one write port, one registered read port.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);
  logic [7:0] r_mem [DEPTH];

  // Storage array write port
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; holds its value when not enabled so a stalled byte stays stable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_data <= 8'h00;
    end else if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end
endmodule

// File: rtl/uart_crc_frame_rx.sv
// Deframes LEN/payload/CRC-8 frames from a UART byte stream and releases the payload only on a CRC match.
module uart_crc_frame_rx
  import uart_crc_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 200000,
  parameter logic [7:0] CRC_INIT    = 8'h00
) (
  input  logic               clk,
  input  logic               rst_i,
  uart_crc_frame_rx_if.slave bus
);
  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  err_code_e        r_err_code;
  err_code_e        w_err_code;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_last_idx;
  logic [7:0]       r_crc;
  logic [TMR_W-1:0] r_timer;
  logic [15:0]      r_err_cnt;
  logic             r_rd_done;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_frame_ok;
  logic             r_frame_err;
  logic             w_in_frame;
  logic             w_len_bad;
  logic             w_timeout;
  logic             w_fire;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_ok;
  logic             w_err;
  logic [7:0]       w_rd_data;

  assign w_in_frame = (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);
  assign w_len_bad  = (bus.rx_data_i == 8'd0) || (bus.rx_data_i > 8'(MAX_LEN));
  assign w_timeout  = w_in_frame && !bus.rx_valid_i && (r_timer == TMR_W'(TIMEOUT_CYC - 1));
  assign w_fire     = r_out_valid && bus.out_ready_i;
  assign w_wr_en    = (r_state == ST_PAYLOAD) && bus.rx_valid_i;
  // A new read is issued when the output slot is empty or being emptied this cycle.
  assign w_rd_en    = (r_state == ST_DRAIN) && !r_rd_done && (!r_out_valid || w_fire);

  // State register
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle frame verdict
  always_comb begin
    w_state_nxt = r_state;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_err_code  = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (bus.rx_valid_i && w_len_bad) begin
          w_err      = 1'b1;
          w_err_code = ERR_LEN;
        end else if (bus.rx_valid_i) begin
          w_state_nxt = ST_PAYLOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (w_timeout) begin
          w_err       = 1'b1;
          w_err_code  = ERR_TIMEOUT;
          w_state_nxt = ST_IDLE;
        end else if (w_wr_en && (r_wr_ptr == r_last_idx)) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_CHECK: begin
        if (w_timeout) begin
          w_err       = 1'b1;
          w_err_code  = ERR_TIMEOUT;
          w_state_nxt = ST_IDLE;
        end else if (bus.rx_valid_i && (bus.rx_data_i == r_crc)) begin
          w_ok        = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else if (bus.rx_valid_i) begin
          w_err       = 1'b1;
          w_err_code  = ERR_CRC;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_DRAIN: begin
        if (bus.rx_valid_i) begin
          w_err      = 1'b1;
          w_err_code = ERR_TIMEOUT;
        end else begin
          w_err      = 1'b0;
        end
        if (w_fire && r_out_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame capture: length, write pointer, running CRC and inter-byte timer
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_last_idx <= '0;
      r_wr_ptr   <= '0;
      r_crc      <= CRC_INIT;
      r_timer    <= '0;
    end else begin
      if ((r_state == ST_IDLE) && bus.rx_valid_i) begin
        r_last_idx <= PTR_W'(bus.rx_data_i - 8'd1);
        r_wr_ptr   <= '0;
        r_crc      <= CRC_INIT;
      end else if (w_wr_en) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1'b1);
        r_crc      <= crc8_update(r_crc, bus.rx_data_i);
      end
      if (bus.rx_valid_i || !w_in_frame || w_timeout) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TMR_W'(1'b1);
      end
    end
  end

  // Drain read side and output stream flags
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_ptr    <= '0;
      r_rd_done   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_ok) begin
        r_rd_ptr  <= '0;
        r_rd_done <= 1'b0;
      end else if (w_rd_en) begin
        r_rd_done <= (r_rd_ptr == r_last_idx);
        r_rd_ptr  <= (r_rd_ptr == r_last_idx) ? r_rd_ptr : (r_rd_ptr + PTR_W'(1'b1));
      end
      if (w_rd_en) begin
        r_out_valid <= 1'b1;
        r_out_last  <= (r_rd_ptr == r_last_idx);
      end else if (w_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  // Status pulses, sticky error code and saturating error counter (clear wins)
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_cnt   <= 16'h0000;
    end else begin
      r_frame_ok  <= w_ok;
      r_frame_err <= w_err;
      if (bus.err_clr_i) begin
        r_err_code <= ERR_NONE;
        r_err_cnt  <= 16'h0000;
      end else if (w_err) begin
        r_err_code <= w_err_code;
        r_err_cnt  <= (r_err_cnt == 16'hFFFF) ? r_err_cnt : (r_err_cnt + 16'd1);
      end
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (PTR_W)
  ) u_buf (
    .i_clk     (clk),
    .i_rst_n   (rst_i),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.rx_data_i),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign bus.out_valid_o = r_out_valid;
  assign bus.out_data_o  = w_rd_data;
  assign bus.out_last_o  = r_out_last;
  assign bus.frame_ok_o  = r_frame_ok;
  assign bus.frame_err_o = r_frame_err;
  assign bus.err_code_o  = r_err_code;
  assign bus.err_cnt_o   = r_err_cnt;
endmodule

// File: tb/tb_uart_crc_frame_rx.sv
// Randomized and directed bench for uart_crc_frame_rx against a frame-level reference model.
module tb_uart_crc_frame_rx;
  localparam int MAX_LEN = 16;
  localparam int TO_CYC  = 40;

  logic clk   = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  uart_crc_frame_rx_if bus();

  uart_crc_frame_rx #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TO_CYC),
    .CRC_INIT    (8'h00)
  ) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_mis = 0;
  int rdy_mode = 0;
  int ok_seen = 0;
  int err_seen = 0;

  // Reference model state: 0 idle, 1 collecting payload, 2 awaiting CRC, 3 draining
  int         m_mode = 0;
  int         m_len = 0;
  int         m_idle = 0;
  int         due = 0;
  logic [7:0] q_pay[$];
  logic [7:0] q_out[$];
  logic [7:0] got[$];
  logic [7:0] s1[$];
  logic       e_ok = 1'b0;
  logic       e_err = 1'b0;
  logic [1:0] e_code = 2'd0;
  logic [15:0] e_cnt = 16'd0;
  logic       must_valid = 1'b0;
  logic       must_low = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial long division of the message by x^8+x^2+x+1
  function automatic logic [7:0] crc_bits(input logic [7:0] init, input logic [7:0] msg[$]);
    logic [7:0] r;
    r = init;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        if (r[7] ^ msg[i][b]) r = {r[6:0], 1'b0} ^ 8'h07;
        else                  r = {r[6:0], 1'b0};
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic       fire;
    logic       err;
    logic [1:0] code;
    if (!rst_i) begin
      m_mode = 0; m_idle = 0; due = 0;
      q_pay.delete(); q_out.delete();
      e_ok = 1'b0; e_err = 1'b0; e_code = 2'd0; e_cnt = 16'd0;
      must_valid = 1'b0; must_low = 1'b0;
    end else begin
      fire = bus.out_valid_o && bus.out_ready_i;
      if (fire) got.push_back(bus.out_data_o);
      if (fire && q_out.size() > 0) void'(q_out.pop_front());
      must_valid = (due == 1) || (bus.out_valid_o && !bus.out_ready_i);
      must_low = 1'b0;
      if (due > 0) due--;
      err = 1'b0; code = 2'd0; e_ok = 1'b0;
      case (m_mode)
        0: if (bus.rx_valid_i) begin
          if (bus.rx_data_i == 8'd0 || int'(bus.rx_data_i) > MAX_LEN) begin
            err = 1'b1; code = 2'd2;
          end else begin
            m_len = int'(bus.rx_data_i); q_pay.delete(); m_idle = 0; m_mode = 1;
          end
        end
        1, 2: if (bus.rx_valid_i) begin
          m_idle = 0;
          if (m_mode == 1) begin
            q_pay.push_back(bus.rx_data_i);
            if (q_pay.size() == m_len) m_mode = 2;
          end else if (bus.rx_data_i == crc_bits(8'h00, q_pay)) begin
            e_ok = 1'b1; q_out = q_pay; due = 1; must_low = 1'b1; m_mode = 3;
          end else begin
            err = 1'b1; code = 2'd1; m_mode = 0;
          end
        end else begin
          m_idle++;
          if (m_idle == TO_CYC) begin
            err = 1'b1; code = 2'd3; m_mode = 0;
          end
        end
        default: begin
          if (bus.rx_valid_i) begin
            err = 1'b1; code = 2'd3;
          end
          if (q_out.size() == 0) m_mode = 0;
        end
      endcase
      e_err = err;
      if (bus.err_clr_i) begin
        e_cnt = 16'd0; e_code = 2'd0;
      end else if (err) begin
        e_code = code;
        if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_i) begin
      chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rst_out_data", 32'(bus.out_data_o), 32'd0);
      chk("rst_out_last", 32'(bus.out_last_o), 32'd0);
      chk("rst_frame_ok", 32'(bus.frame_ok_o), 32'd0);
      chk("rst_frame_err", 32'(bus.frame_err_o), 32'd0);
      chk("rst_err_code", 32'(bus.err_code_o), 32'd0);
      chk("rst_err_cnt", 32'(bus.err_cnt_o), 32'd0);
    end else begin
      chk("frame_ok", 32'(bus.frame_ok_o), 32'(e_ok));
      chk("frame_err", 32'(bus.frame_err_o), 32'(e_err));
      chk("err_code", 32'(bus.err_code_o), 32'(e_code));
      chk("err_cnt", 32'(bus.err_cnt_o), 32'(e_cnt));
      if (must_valid) chk("out_valid_due", 32'(bus.out_valid_o), 32'd1);
      if (must_low) chk("out_valid_early", 32'(bus.out_valid_o), 32'd0);
      if (q_out.size() == 0) begin
        chk("out_valid_idle", 32'(bus.out_valid_o), 32'd0);
      end else if (bus.out_valid_o) begin
        chk("out_data", 32'(bus.out_data_o), 32'(q_out[0]));
        chk("out_last", 32'(bus.out_last_o), 32'(q_out.size() == 1));
      end
      if (bus.frame_ok_o) ok_seen++;
      if (bus.frame_err_o) err_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.rx_valid_i = 1'b0;
    bus.err_clr_i  = 1'b0;
    case (rdy_mode)
      0:       bus.out_ready_i = 1'b1;
      1:       bus.out_ready_i = ~bus.out_ready_i;
      default: bus.out_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    step();
  endtask

  task automatic send_frame(input logic [7:0] pay[$], input logic [7:0] crc, input int maxgap);
    send(8'(pay.size()));
    foreach (pay[i]) begin
      idle($urandom_range(0, maxgap));
      send(pay[i]);
    end
    idle($urandom_range(0, maxgap));
    send(crc);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((m_mode != 0 || q_out.size() != 0) && n < lim) begin
      step();
      n++;
    end
    if (n >= lim) begin
      n_vec++;
      n_mis++;
      $display("FAIL wait_idle: drain not finished after %0d cycles, %0d bytes left", n, q_out.size());
    end
    idle(2);
  endtask

  task automatic chk_s1(input string name);
    chk({name, "_count"}, 32'(got.size()), 32'd9);
    foreach (got[i]) chk({name, "_byte"}, 32'(got[i]), 32'(8'h31 + 8'(i)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pay[$];
    logic [7:0] c;
    int kind;
    int len;
    bus.rx_valid_i = 1'b0; bus.rx_data_i = 8'h00; bus.out_ready_i = 1'b1; bus.err_clr_i = 1'b0;
    for (int i = 0; i < 9; i++) s1.push_back(8'h31 + 8'(i));
    chk("model_crc_123456789", 32'(crc_bits(8'h00, s1)), 32'h0000_00F4);
    idle(3);
    rst_i = 1'b1;
    idle(2);

    // Good frame, ready held high
    got.delete(); ok_seen = 0;
    send_frame(s1, 8'hF4, 0);
    wait_idle(100);
    chk_s1("s1");
    chk("s1_ok_pulses", 32'(ok_seen), 32'd1);
    chk("s1_cnt", 32'(bus.err_cnt_o), 32'd0);

    // Bad CRC
    got.delete();
    send_frame(s1, 8'hF5, 0);
    idle(3);
    chk("s2_code", 32'(bus.err_code_o), 32'd1);
    chk("s2_cnt", 32'(bus.err_cnt_o), 32'd1);
    chk("s2_no_out", 32'(got.size()), 32'd0);

    // Illegal lengths back to back, then the next byte starts a real frame
    send(8'd0);
    send(8'(MAX_LEN + 1));
    pay.delete(); pay.push_back(8'hA5);
    send_frame(pay, crc_bits(8'h00, pay), 0);
    wait_idle(100);
    chk("s3_code", 32'(bus.err_code_o), 32'd2);
    chk("s3_cnt", 32'(bus.err_cnt_o), 32'd3);
    chk("s3_count", 32'(got.size()), 32'd1);
    chk("s3_byte", 32'(got[0]), 32'h0000_00A5);

    // Inter-byte timeout, then recovery
    send(8'd4); send(8'h11); send(8'h22);
    idle(TO_CYC + 4);
    chk("s4_code", 32'(bus.err_code_o), 32'd3);
    chk("s4_cnt", 32'(bus.err_cnt_o), 32'd4);
    got.delete();
    send_frame(s1, 8'hF4, 3);
    wait_idle(100);
    chk_s1("s4_recover");

    // Toggling ready plus a stray byte during drain
    got.delete(); rdy_mode = 1;
    send_frame(s1, 8'hF4, 0);
    idle(4);
    send(8'h55);
    wait_idle(100);
    rdy_mode = 0;
    chk_s1("s5");
    chk("s5_cnt", 32'(bus.err_cnt_o), 32'd5);
    chk("s5_code", 32'(bus.err_code_o), 32'd3);

    // Randomized frames
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 5) == 0) begin
        bus.err_clr_i = 1'b1;
        step();
      end
      if (kind == 0) begin
        send(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        len = $urandom_range(1, MAX_LEN);
        pay.delete();
        repeat (len) pay.push_back(8'($urandom_range(0, 255)));
        c = crc_bits(8'h00, pay);
        if (kind == 1) c = c ^ 8'(1 << $urandom_range(0, 7));
        if (kind == 2) begin
          send(8'(len));
          send(pay[0]);
          idle(TO_CYC + 2);
        end else begin
          send_frame(pay, c, 2);
          if (kind == 3) begin
            idle(2);
            send(8'($urandom_range(0, 255)));
          end
        end
      end
      wait_idle(400);
    end
    rdy_mode = 0;
    idle(2);

    // Reset mid-payload and mid-drain
    send(8'd9); send(8'h31); send(8'h32);
    rst_i = 1'b0;
    idle(2);
    rst_i = 1'b1;
    idle(3);
    rdy_mode = 1;
    send_frame(s1, 8'hF4, 0);
    idle(3);
    rst_i = 1'b0;
    idle(2);
    rst_i = 1'b1;
    idle(5);
    rdy_mode = 0;
    got.delete(); ok_seen = 0;
    send_frame(s1, 8'hF4, 0);
    wait_idle(100);
    chk_s1("s6");
    chk("s6_ok_pulses", 32'(ok_seen), 32'd1);
    chk("s6_cnt", 32'(bus.err_cnt_o), 32'd0);

    // Clear coincident with an error
    send(8'd0);
    idle(1);
    chk("clr_pre_cnt", 32'(bus.err_cnt_o), 32'd1);
    err_seen = 0;
    bus.err_clr_i = 1'b1;
    send(8'd0);
    idle(2);
    chk("clr_err_pulse", 32'(err_seen), 32'd1);
    chk("clr_cnt", 32'(bus.err_cnt_o), 32'd0);
    chk("clr_code", 32'(bus.err_code_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
